// File: rtl/relogio_pkg.sv
// Shared types and helpers for the settable time-of-day clock.
// Optional alarm feature is built when ALARM_EN is defined.
package relogio_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    SET_AH = 3'd4,
    SET_AM = 3'd5
  } state_t;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t MAX_SEC  = 8'h59;
  localparam bcd2_t MAX_MIN  = 8'h59;
  localparam bcd2_t MAX_HOUR = 8'h23;

  // Converts a 24 h BCD hour into its 12 h BCD display value (00 -> 12, 13..23 -> 01..11).
  function automatic bcd2_t to_12h(input bcd2_t h);
    logic [4:0] bin;
    logic [4:0] adj;
    bin = {1'b0, h[7:4]} * 5'd10 + {1'b0, h[3:0]};
    if (bin == 5'd0) begin
      adj = 5'd12;
    end else if (bin > 5'd12) begin
      adj = bin - 5'd12;
    end else begin
      adj = bin;
    end
    if (adj >= 5'd10) begin
      to_12h = {4'd1, 4'(adj - 5'd10)};
    end else begin
      to_12h = {4'd0, 4'(adj)};
    end
  endfunction

endpackage

// File: rtl/relogio_parametrizado_bcd_mod_counter.sv
// Two-digit BCD counter wrapping from MAX to 00, with synchronous clear.
// carry is combinational: high while inc is asserted at MAX.
module bcd_mod_counter
  import relogio_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,
  input  logic  clr,
  output bcd2_t value,
  output logic  carry
);

  logic at_max;

  assign at_max = (value == MAX);
  assign carry  = inc & at_max;

  // BCD increment with wrap at MAX; clear takes priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (at_max) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/relogio_parametrizado.sv
// Settable 24 h clock with 12/24 h display, field-edit FSM and blink mask.
// Ticks are derived from CLOCK_50 via CLK_HZ. Define ALARM_EN to add the
// alarm registers, the two alarm-edit states and the alarm ring output.
module relogio_parametrizado
  import relogio_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       mode_12h,
  input  logic       alarm_on,
  output logic [7:0] bcd_h,
  output logic [7:0] bcd_m,
  output logic [7:0] bcd_s,
  output logic       pm,
  output logic [2:0] blank,
  output logic       alarm
);

  localparam int DIV_MAX = CLK_HZ / 2 - 1;
  localparam int DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(DIV_MAX);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic             sec_phase;
  logic             blink_phase;
  logic             mode_prev;
  logic             inc_prev;
  logic             half_tick;
  logic             sec_tick;
  logic             mode_edge;
  logic             inc_edge;
  logic             inc_only;
  logic             mode_adv;
  logic             to_run;
  logic             in_run;
  logic             s_inc, s_clr, s_carry;
  logic             m_inc, m_carry;
  logic             h_inc;
  logic             unused_h_carry;
  bcd2_t            hour, minute, second;
  bcd2_t            disp_h, disp_m, disp_s;

  assign half_tick = (div == DIV_TERM);
  assign sec_tick  = half_tick & sec_phase;
  assign mode_edge = btn_mode & ~mode_prev;
  assign inc_edge  = btn_inc & ~inc_prev;
  assign inc_only  = inc_edge & ~mode_edge;
  assign in_run    = (state == RUN);
  assign to_run    = mode_adv & (state != RUN) & (state_next == RUN);

  // Half-second divider and second phase; restarted when an edit returns to RUN.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div       <= '0;
      sec_phase <= 1'b0;
    end else if (to_run) begin
      div       <= '0;
      sec_phase <= 1'b0;
    end else if (half_tick) begin
      div       <= '0;
      sec_phase <= ~sec_phase;
    end else begin
      div       <= div + DIV_W'(1);
      sec_phase <= sec_phase;
    end
  end

  // Blink phase free-runs at the half-second rate.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      blink_phase <= 1'b0;
    end else if (half_tick) begin
      blink_phase <= ~blink_phase;
    end else begin
      blink_phase <= blink_phase;
    end
  end

  // Previous button levels for rising-edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
    end
  end

  // Field-select sequence, advanced by accepted mode presses.
  always_comb begin
    state_next = state;
    if (mode_adv) begin
      case (state)
        RUN:    state_next = SET_H;
        SET_H:  state_next = SET_M;
        SET_M:  state_next = SET_S;
`ifdef ALARM_EN
        SET_S:  state_next = SET_AH;
        SET_AH: state_next = SET_AM;
        SET_AM: state_next = RUN;
`else
        SET_S:  state_next = RUN;
`endif
        default: state_next = RUN;
      endcase
    end else begin
      state_next = state;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Time counters: run-mode ticking and carries, or single-field edits (no carry).
  assign s_inc = in_run & sec_tick;
  assign s_clr = (state == SET_S) & inc_only;
  assign m_inc = (in_run & s_carry) | ((state == SET_M) & inc_only);
  assign h_inc = (in_run & m_carry) | ((state == SET_H) & inc_only);

  bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
    .clk(CLOCK_50), .rst_n(reset), .inc(s_inc), .clr(s_clr), .value(second), .carry(s_carry)
  );
  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk(CLOCK_50), .rst_n(reset), .inc(m_inc), .clr(1'b0), .value(minute), .carry(m_carry)
  );
  bcd_mod_counter #(.MAX(MAX_HOUR)) u_hour (
    .clk(CLOCK_50), .rst_n(reset), .inc(h_inc), .clr(1'b0), .value(hour), .carry(unused_h_carry)
  );

`ifdef ALARM_EN
  bcd2_t alarm_h, alarm_m;
  logic  unused_ah_carry, unused_am_carry;
  logic  alarm_r;
  logic  match, match_prev;
  logic  unused_alarm_on;

  assign unused_alarm_on = 1'b0;
  assign mode_adv = mode_edge & ~alarm_r;
  assign match    = (hour == alarm_h) & (minute == alarm_m) & (second == 8'h00);
  assign alarm    = alarm_r;

  bcd_mod_counter #(.MAX(MAX_HOUR)) u_alarm_h (
    .clk(CLOCK_50), .rst_n(reset), .inc((state == SET_AH) & inc_only), .clr(1'b0),
    .value(alarm_h), .carry(unused_ah_carry)
  );
  bcd_mod_counter #(.MAX(MAX_MIN)) u_alarm_m (
    .clk(CLOCK_50), .rst_n(reset), .inc((state == SET_AM) & inc_only), .clr(1'b0),
    .value(alarm_m), .carry(unused_am_carry)
  );

  // Ring once when the running time reaches the alarm minute; any clear source wins.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      alarm_r    <= 1'b0;
      match_prev <= 1'b0;
    end else begin
      match_prev <= match;
      if (mode_edge | ~alarm_on | m_inc) begin
        alarm_r <= 1'b0;
      end else if (in_run & match & ~match_prev) begin
        alarm_r <= 1'b1;
      end else begin
        alarm_r <= alarm_r;
      end
    end
  end

  // Display source: alarm HH:MM:00 while editing the alarm, live time otherwise.
  always_comb begin
    disp_h = hour;
    disp_m = minute;
    disp_s = second;
    if ((state == SET_AH) || (state == SET_AM)) begin
      disp_h = alarm_h;
      disp_m = alarm_m;
      disp_s = 8'h00;
    end else begin
      disp_h = hour;
      disp_m = minute;
      disp_s = second;
    end
  end
`else
  logic unused_alarm_on;

  assign unused_alarm_on = alarm_on;
  assign mode_adv = mode_edge;
  assign alarm    = 1'b0;

  // Display source is always the live time.
  always_comb begin
    disp_h = hour;
    disp_m = minute;
    disp_s = second;
  end
`endif

  assign bcd_h = mode_12h ? to_12h(disp_h) : disp_h;
  assign bcd_m = disp_m;
  assign bcd_s = disp_s;
  assign pm    = mode_12h & (disp_h >= 8'h12);

  // Blank mask: only the field being edited blinks.
  always_comb begin
    blank = 3'b000;
    case (state)
      SET_H, SET_AH: blank = {blink_phase, 2'b00};
      SET_M, SET_AM: blank = {1'b0, blink_phase, 1'b0};
      SET_S:         blank = {2'b00, blink_phase};
      default:       blank = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_relogio_parametrizado.sv
// Directed + randomized bench for relogio_parametrizado with CLK_HZ = 4.
// Reference model keeps time as seconds-of-day and the edit state as an index.
module tb_relogio_parametrizado;

  localparam int CLK_HZ = 4;
  localparam int HALF   = CLK_HZ / 2;
`ifdef ALARM_EN
  localparam int NSTATES = 6;
`else
  localparam int NSTATES = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       mode_12h = 1'b0;
  logic       alarm_on = 1'b0;
  logic [7:0] bcd_h, bcd_m, bcd_s;
  logic       pm;
  logic [2:0] blank;
  logic       alarm;

  int errors = 0;
  int checks = 0;

  // reference model state
  int t_sec;
  int st;
  int sub;
  bit blink;
  bit prev_m, prev_i;
  int ah, am;
  bit alarm_block;

  always #5 clk = ~clk;

  relogio_parametrizado #(.CLK_HZ(CLK_HZ)) dut (
    .CLOCK_50(clk), .reset(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .mode_12h(mode_12h), .alarm_on(alarm_on), .bcd_h(bcd_h), .bcd_m(bcd_m),
    .bcd_s(bcd_s), .pm(pm), .blank(blank), .alarm(alarm)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int h, m, s, hd;
    logic [2:0] eb;
    if (st == 4 || st == 5) begin
      h = ah; m = am; s = 0;
    end else begin
      h = t_sec / 3600; m = (t_sec / 60) % 60; s = t_sec % 60;
    end
    if (mode_12h) hd = (h % 12 == 0) ? 12 : h % 12;
    else hd = h;
    eb = 3'b000;
    if (st == 1 || st == 4) eb[2] = blink;
    if (st == 2 || st == 5) eb[1] = blink;
    if (st == 3) eb[0] = blink;
    check({tag, ".h"}, bcd_h, to_bcd(hd));
    check({tag, ".m"}, bcd_m, to_bcd(m));
    check({tag, ".s"}, bcd_s, to_bcd(s));
    check({tag, ".pm"}, {7'd0, pm}, {7'd0, (mode_12h && h >= 12)});
    check({tag, ".blank"}, {5'd0, blank}, {5'd0, eb});
`ifndef ALARM_EN
    check({tag, ".alarm"}, {7'd0, alarm}, 8'd0);
`endif
  endtask

  // one clock edge of the behavioural model
  task automatic model_edge(input bit bm, input bit bi);
    bit me, ie, inc_only, ht, stk;
    int h, m, s;
    me = bm && !prev_m;
    ie = bi && !prev_i;
    inc_only = ie && !me;
    ht = (sub % HALF) == HALF - 1;
    stk = (sub == CLK_HZ - 1);
    h = t_sec / 3600; m = (t_sec / 60) % 60; s = t_sec % 60;
    if (st == 0 && stk) t_sec = (t_sec + 1) % 86400;
    if (st == 1 && inc_only) t_sec = ((h + 1) % 24) * 3600 + m * 60 + s;
    if (st == 2 && inc_only) t_sec = h * 3600 + ((m + 1) % 60) * 60 + s;
    if (st == 3 && inc_only) t_sec = h * 3600 + m * 60;
    if (st == 4 && inc_only) ah = (ah + 1) % 24;
    if (st == 5 && inc_only) am = (am + 1) % 60;
    sub = (sub + 1) % CLK_HZ;
    if (ht) blink = !blink;
    if (me) begin
      if (alarm_block) begin
        alarm_block = 1'b0;
      end else begin
        if (st == NSTATES - 1) sub = 0;
        st = (st + 1) % NSTATES;
      end
    end
    prev_m = bm;
    prev_i = bi;
  endtask

  task automatic step(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc = bi;
    @(posedge clk);
    model_edge(bm, bi);
    #1;
    check_all("step");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic press_mode();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
  endtask

  task automatic goto_state(input int target);
    for (int k = 0; k < 8 && st != target; k++) press_mode();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    t_sec = 0; st = 0; sub = 0; blink = 1'b0;
    prev_m = 1'b0; prev_i = 1'b0; ah = 0; am = 0; alarm_block = 1'b0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: first second, then 23:59:59 -> 00:00:00 rollover
    do_reset();
    run(4);
    check("t1_first_sec", bcd_s, 8'h01);
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(59);
    press_mode();
    press_inc(1);
    goto_state(0);
    run(235);
    check("t1_pre_h", bcd_h, 8'h23);
    check("t1_pre_m", bcd_m, 8'h59);
    check("t1_pre_s", bcd_s, 8'h59);
    run(4);
    check("t1_roll_h", bcd_h, 8'h00);
    check("t1_roll_m", bcd_m, 8'h00);
    check("t1_roll_s", bcd_s, 8'h00);
    check("t1_roll_pm", {7'd0, pm}, 8'd0);

    // 2: hour edit wraps through 24 presses, other fields frozen
    press_mode();
    press_inc(25);
    check("t2_h", bcd_h, 8'h01);
    check("t2_m", bcd_m, 8'h00);
    check("t2_s", bcd_s, 8'h00);

    // 3: 13:05:30 in 12 h mode, then hour 00
    press_inc(12);
    press_mode();
    press_inc(5);
    press_mode();
    press_inc(1);
    goto_state(0);
    run(119);
    mode_12h = 1'b1;
    #1;
    check("t3_h12", bcd_h, 8'h01);
    check("t3_pm", {7'd0, pm}, 8'd1);
    check("t3_m", bcd_m, 8'h05);
    check("t3_s", bcd_s, 8'h30);
    press_mode();
    press_inc(11);
    check("t3_midnight_h", bcd_h, 8'h12);
    check("t3_midnight_pm", {7'd0, pm}, 8'd0);

    // 4: simultaneous mode and inc edges in SET_M
    mode_12h = 1'b0;
    press_mode();
    step(1'b1, 1'b1);
    check("t4_m_kept", bcd_m, 8'h05);
    check("t4_blank_hm", {6'd0, blank[2:1]}, 8'd0);
    step(1'b0, 1'b0);

    // 5: reset in the middle of a minute edit
    goto_state(2);
    press_inc(2);
    check("t5_m07", bcd_m, 8'h07);
    do_reset();
    check("t5_h", bcd_h, 8'h00);
    check("t5_m", bcd_m, 8'h00);
    check("t5_s", bcd_s, 8'h00);
    check("t5_blank", {5'd0, blank}, 8'd0);
    run(2);

    // randomized presses and display-mode changes
    for (int i = 0; i < 400; i++) begin
      if (i % 32 == 0) mode_12h = 1'($urandom_range(0, 1));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    mode_12h = 1'b0;

    // 6: alarm
    do_reset();
`ifdef ALARM_EN
    goto_state(5);
    press_inc(1);
    check("t6_alarm_m", bcd_m, 8'h01);
    goto_state(0);
    alarm_on = 1'b1;
    run(242);
    check("t6_ring", {7'd0, alarm}, 8'd1);
    check("t6_ring_m", bcd_m, 8'h01);
    alarm_block = 1'b1;
    step(1'b1, 1'b0);
    check("t6_ack", {7'd0, alarm}, 8'd0);
    check("t6_ack_run", {5'd0, blank}, 8'd0);
    step(1'b0, 1'b0);
`else
    alarm_on = 1'b1;
    run(242);
    check("t6_no_alarm", {7'd0, alarm}, 8'd0);
    check("t6_m", bcd_m, 8'h01);
`endif
    alarm_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
